// File: rtl/if_fetch.sv
// Instruction-fetch stage: owns the PC, issues MMU lookups and instruction-bus reads,
// and presents one instruction per cycle to the IF/ID register.
module if_fetch #(
    parameter logic [31:0] PC_RESET_ADDR = 32'hBFC0_0000,
    parameter int          ADDR_W        = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [5:0]        stall,
    input  logic              flush,
    input  logic [ADDR_W-1:0] flush_pc,
    input  logic              branch_flag,
    input  logic [ADDR_W-1:0] branch_target,
    output logic [ADDR_W-1:0] inst_addr_v,
    input  logic [ADDR_W-1:0] inst_addr_p,
    input  logic              tlb_miss,
    input  logic              tlb_valid,
    output logic              ibus_req,
    output logic [ADDR_W-1:0] ibus_addr,
    input  logic              ibus_ready,
    input  logic [ADDR_W-1:0] ibus_rdata,
    output logic [ADDR_W-1:0] if_pc,
    output logic [ADDR_W-1:0] if_inst_addr_v,
    output logic [ADDR_W-1:0] if_inst,
    output logic              if_miss,
    output logic              if_valid,
    output logic              stall_req
);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] inst_buf_q, inst_buf_d;
    logic              br_pend_q, br_pend_d;
    logic [ADDR_W-1:0] br_tgt_q, br_tgt_d;
    logic [ADDR_W-1:0] pc_pend_q, pc_pend_d;

    logic              req;
    logic              advance;
    logic              trans_ok;
    logic [ADDR_W-1:0] next_pc;
    logic              unused_stall;

    // Only stall[0] concerns IF; the other pipeline stall bits are ignored here.
    assign unused_stall = ^stall[5:1];

    assign trans_ok = ~tlb_miss & tlb_valid;

    // A branch seen while the PC was frozen takes priority over one arriving now.
    assign next_pc = br_pend_q   ? br_tgt_q      :
                     branch_flag ? branch_target :
                                   pc_q + ADDR_W'(4);

    // NOTE: every variable written below gets a default first, so no path leaves one
    // unassigned and no latch is inferred.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        inst_buf_d = inst_buf_q;
        br_pend_d  = br_pend_q;
        br_tgt_d   = br_tgt_q;
        pc_pend_d  = pc_pend_q;
        req        = 1'b0;
        advance    = 1'b0;
        if_inst    = '0;
        if_miss    = tlb_miss;
        if_valid   = tlb_valid;
        stall_req  = 1'b0;

        case (state_q)
            FETCH: begin
                if (!trans_ok) begin
                    // Faulting fetch flows down as a bubble carrying the MMU flags.
                    advance = ~stall[0];
                end else begin
                    req = 1'b1;
                    if (ibus_ready) begin
                        if (!stall[0]) begin
                            if_inst = ibus_rdata;
                            advance = 1'b1;
                        end else begin
                            inst_buf_d = ibus_rdata;
                            state_d    = HOLD;
                        end
                    end else begin
                        stall_req = 1'b1;
                    end
                end
            end
            HOLD: begin
                if_inst = inst_buf_q;
                if (!stall[0]) begin
                    advance = 1'b1;
                    state_d = FETCH;
                end
            end
            DRAIN: begin
                // Flushed read still owns the bus; wait it out and discard the data.
                req       = 1'b1;
                if_miss   = 1'b0;
                if_valid  = 1'b1;
                stall_req = 1'b1;
                if (ibus_ready) begin
                    pc_d    = pc_pend_q;
                    state_d = FETCH;
                end
            end
            default: state_d = FETCH;
        endcase

        if (advance) begin
            pc_d      = next_pc;
            br_pend_d = 1'b0;
        end else if (branch_flag) begin
            br_pend_d = 1'b1;
            br_tgt_d  = branch_target;
        end

        if (flush) begin
            br_pend_d = 1'b0;
            if (req && !ibus_ready) begin
                state_d   = DRAIN;
                pc_pend_d = flush_pc;
                pc_d      = pc_q;
            end else begin
                pc_d    = flush_pc;
                state_d = FETCH;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= FETCH;
            pc_q       <= PC_RESET_ADDR;
            inst_buf_q <= '0;
            br_pend_q  <= 1'b0;
            br_tgt_q   <= '0;
            pc_pend_q  <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            inst_buf_q <= inst_buf_d;
            br_pend_q  <= br_pend_d;
            br_tgt_q   <= br_tgt_d;
            pc_pend_q  <= pc_pend_d;
        end
    end

    // Request is gated by reset so a transfer in flight is dropped immediately.
    assign ibus_req       = req & ~rst;
    assign ibus_addr      = inst_addr_p;
    assign inst_addr_v    = pc_q;
    assign if_pc          = pc_q;
    assign if_inst_addr_v = pc_q;

endmodule

// File: tb/tb_if_fetch.sv
// Directed bench for if_fetch: bus timing, stall hold, delay-slot branch, flush drain,
// TLB fault bubble and PC wrap. MMU maps VA to PA by clearing the top three bits.
module tb_if_fetch;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [5:0]  stall = '0;
    logic        flush = 1'b0;
    logic [31:0] flush_pc = '0;
    logic        branch_flag = 1'b0;
    logic [31:0] branch_target = '0;
    logic [31:0] inst_addr_v;
    logic [31:0] inst_addr_p;
    logic        tlb_miss = 1'b0;
    logic        tlb_valid = 1'b1;
    logic        ibus_req;
    logic [31:0] ibus_addr;
    logic        ibus_ready = 1'b0;
    logic [31:0] ibus_rdata = '0;
    logic [31:0] if_pc;
    logic [31:0] if_inst_addr_v;
    logic [31:0] if_inst;
    logic        if_miss;
    logic        if_valid;
    logic        stall_req;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    assign inst_addr_p = inst_addr_v & 32'h1FFF_FFFF;

    if_fetch dut (
        .clk            (clk),
        .rst            (rst),
        .stall          (stall),
        .flush          (flush),
        .flush_pc       (flush_pc),
        .branch_flag    (branch_flag),
        .branch_target  (branch_target),
        .inst_addr_v    (inst_addr_v),
        .inst_addr_p    (inst_addr_p),
        .tlb_miss       (tlb_miss),
        .tlb_valid      (tlb_valid),
        .ibus_req       (ibus_req),
        .ibus_addr      (ibus_addr),
        .ibus_ready     (ibus_ready),
        .ibus_rdata     (ibus_rdata),
        .if_pc          (if_pc),
        .if_inst_addr_v (if_inst_addr_v),
        .if_inst        (if_inst),
        .if_miss        (if_miss),
        .if_valid       (if_valid),
        .stall_req      (stall_req)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #2;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        #1 rst = 1'b1;
        #2;
        check("rst_req", {31'd0, ibus_req}, 32'd0);
        check("rst_pc", if_pc, 32'hBFC0_0000);

        // Zero-wait bus, no stall: one fetch per cycle.
        next_cycle();
        rst = 1'b0;
        ibus_ready = 1'b1;
        ibus_rdata = 32'h1111_1111;
        settle();
        check("seq0_req", {31'd0, ibus_req}, 32'd1);
        check("seq0_addr", ibus_addr, 32'h1FC0_0000);
        check("seq0_inst", if_inst, 32'h1111_1111);
        check("seq0_stall", {31'd0, stall_req}, 32'd0);
        check("seq0_va", if_inst_addr_v, 32'hBFC0_0000);
        next_cycle();
        ibus_rdata = 32'h2222_2222;
        settle();
        check("seq1_addr", ibus_addr, 32'h1FC0_0004);
        check("seq1_inst", if_inst, 32'h2222_2222);
        next_cycle();
        settle();
        check("seq2_addr", ibus_addr, 32'h1FC0_0008);
        check("seq2_stall", {31'd0, stall_req}, 32'd0);

        // Three wait states at BFC0000C.
        next_cycle();
        ibus_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            settle();
            check("wait_stall", {31'd0, stall_req}, 32'd1);
            check("wait_addr", ibus_addr, 32'h1FC0_000C);
            next_cycle();
        end
        ibus_ready = 1'b1;
        ibus_rdata = 32'h3333_3333;
        settle();
        check("wait_done_stall", {31'd0, stall_req}, 32'd0);
        check("wait_done_inst", if_inst, 32'h3333_3333);
        check("wait_done_pc", if_pc, 32'hBFC0_000C);

        // Completion under stall[0]: word buffered, held for two cycles.
        next_cycle();
        ibus_rdata = 32'h4444_4444;
        stall = 6'b000001;
        settle();
        check("hold_pc0", if_pc, 32'hBFC0_0010);
        check("hold_stall0", {31'd0, stall_req}, 32'd0);
        next_cycle();
        ibus_rdata = 32'h0BAD_0BAD;
        settle();
        check("hold1_req", {31'd0, ibus_req}, 32'd0);
        check("hold1_inst", if_inst, 32'h4444_4444);
        check("hold1_pc", if_pc, 32'hBFC0_0010);
        next_cycle();
        stall = 6'b000000;
        settle();
        check("hold2_req", {31'd0, ibus_req}, 32'd0);
        check("hold2_inst", if_inst, 32'h4444_4444);

        // Branch at BFC00010 resolves in ID while IF fetches its slot BFC00014.
        next_cycle();
        branch_flag = 1'b1;
        branch_target = 32'hBFC0_0100;
        ibus_rdata = 32'h5555_5555;
        settle();
        check("slot_pc", if_pc, 32'hBFC0_0014);
        check("slot_inst", if_inst, 32'h5555_5555);

        // Branch while fetch is waiting: target must be remembered.
        next_cycle();
        ibus_ready = 1'b0;
        branch_target = 32'hBFC0_0200;
        settle();
        check("tgt_pc", if_pc, 32'hBFC0_0100);
        check("tgt_addr", ibus_addr, 32'h1FC0_0100);
        check("tgt_stall", {31'd0, stall_req}, 32'd1);
        next_cycle();
        branch_flag = 1'b0;
        ibus_ready = 1'b1;
        ibus_rdata = 32'h6666_6666;
        settle();
        check("pend_pc", if_pc, 32'hBFC0_0100);
        check("pend_inst", if_inst, 32'h6666_6666);
        next_cycle();
        ibus_ready = 1'b0;
        settle();
        check("pend_tgt_pc", if_pc, 32'hBFC0_0200);
        check("pend_tgt_stall", {31'd0, stall_req}, 32'd1);

        // Flush during an outstanding read: drain it, drop the data, redirect.
        next_cycle();
        flush = 1'b1;
        flush_pc = 32'h8000_0180;
        settle();
        next_cycle();
        flush = 1'b0;
        settle();
        check("drain_req", {31'd0, ibus_req}, 32'd1);
        check("drain_addr", ibus_addr, 32'h1FC0_0200);
        check("drain_inst", if_inst, 32'h0);
        check("drain_stall", {31'd0, stall_req}, 32'd1);
        check("drain_valid", {31'd0, if_valid}, 32'd1);
        check("drain_miss", {31'd0, if_miss}, 32'd0);
        next_cycle();
        ibus_ready = 1'b1;
        ibus_rdata = 32'hDEAD_BEEF;
        settle();
        check("drain_drop_inst", if_inst, 32'h0);
        check("drain_drop_stall", {31'd0, stall_req}, 32'd1);
        next_cycle();
        ibus_rdata = 32'h7777_7777;
        settle();
        check("redir_pc", if_pc, 32'h8000_0180);
        check("redir_addr", ibus_addr, 32'h0000_0180);
        check("redir_inst", if_inst, 32'h7777_7777);

        // Flush with no outstanding read redirects immediately.
        next_cycle();
        flush = 1'b1;
        flush_pc = 32'h0040_0000;
        settle();
        next_cycle();
        flush = 1'b0;
        tlb_miss = 1'b1;
        tlb_valid = 1'b0;
        ibus_ready = 1'b0;
        settle();
        check("tlb_pc", if_pc, 32'h0040_0000);
        check("tlb_req", {31'd0, ibus_req}, 32'd0);
        check("tlb_miss", {31'd0, if_miss}, 32'd1);
        check("tlb_valid", {31'd0, if_valid}, 32'd0);
        check("tlb_inst", if_inst, 32'h0);
        check("tlb_stall", {31'd0, stall_req}, 32'd0);

        // Fault bubble still advances; then wrap from the top of the address space.
        next_cycle();
        tlb_miss = 1'b0;
        tlb_valid = 1'b1;
        ibus_ready = 1'b1;
        settle();
        check("tlb_adv_pc", if_pc, 32'h0040_0004);
        flush = 1'b1;
        flush_pc = 32'hFFFF_FFFC;
        next_cycle();
        flush = 1'b0;
        ibus_rdata = 32'h8888_8888;
        settle();
        check("wrap_pc0", if_pc, 32'hFFFF_FFFC);
        check("wrap_addr0", ibus_addr, 32'h1FFF_FFFC);
        next_cycle();
        settle();
        check("wrap_pc1", if_pc, 32'h0000_0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
